// File: rtl/branch_resolve_unit_pkg.sv
// Shared LC-3b types and resolver state encoding for the MEM-stage branch resolver.
package branch_resolve_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic {
        BRS_RUN    = 1'b0,
        BRS_SQUASH = 1'b1
    } brs_state_t;

    function automatic logic is_uncond_op(lc3b_opcode op);
        return (op == op_jmp) || (op == op_jsr) || (op == op_trap);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// MEM-stage control-op bundle and front-end/training outputs of the branch resolver.
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 mem_valid;
    lc3b_opcode           mem_opcode;
    logic [2:0]           mem_nzp;
    logic [2:0]           cc_nzp;
    lc3b_word             mem_pc;
    logic                 mem_pred_taken;
    logic                 mem_predictor;
    lc3b_word             mem_pred_target;
    lc3b_word             mem_actual_target;

    logic                 take_jump;
    logic                 bad_uncond_jump;
    logic                 mispredict;
    lc3b_word             redirect_pc;
    logic                 wb_take_jump;
    logic                 wb_predict_taken;
    logic                 wb_predictor;
    lc3b_word             resolved_pc;
    logic                 update_branch_history;
    logic                 btb_we;
    lc3b_word             btb_wtarget;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport slave (
        input  stall, mem_valid, mem_opcode, mem_nzp, cc_nzp, mem_pc,
               mem_pred_taken, mem_predictor, mem_pred_target, mem_actual_target,
        output take_jump, bad_uncond_jump, mispredict, redirect_pc,
               wb_take_jump, wb_predict_taken, wb_predictor, resolved_pc,
               update_branch_history, btb_we, btb_wtarget,
               branch_count, mispredict_count
    );

    modport master (
        output stall, mem_valid, mem_opcode, mem_nzp, cc_nzp, mem_pc,
               mem_pred_taken, mem_predictor, mem_pred_target, mem_actual_target,
        input  take_jump, bad_uncond_jump, mispredict, redirect_pc,
               wb_take_jump, wb_predict_taken, wb_predictor, resolved_pc,
               update_branch_history, btb_we, btb_wtarget,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolver: compares real control-op outcome with the IF-time
// prediction, requests redirects, trains the predictor/BTB and counts events.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int SQUASH_DEPTH = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    brs_state_t state, state_nxt;
    logic [2:0] sq_cnt, sq_cnt_nxt;
    logic       done;
    logic       is_br, is_unc, ctl, tgt_miss, take, br_wrong, unc_wrong, wrong;
    logic       mispredict, resolve;

    logic       wb_take_q, wb_pred_q, wb_predictor_q, ubh_q, btb_we_q;
    lc3b_word   resolved_pc_q, btb_wtarget_q;
    logic [CNT_WIDTH-1:0] branch_cnt, mispred_cnt;

    always_comb begin
        is_br    = (bus.mem_opcode == op_br);
        is_unc   = is_uncond_op(bus.mem_opcode);
        tgt_miss = (bus.mem_pred_target != bus.mem_actual_target);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BRS_RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    // A stalled op that already redirected (done) is still the right-path op,
    // so its release edge is not counted as a squashed slot.
    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        case (state)
            BRS_RUN: begin
                if (mispredict) begin
                    state_nxt  = BRS_SQUASH;
                    sq_cnt_nxt = 3'(SQUASH_DEPTH);
                end
            end
            BRS_SQUASH: begin
                if (!bus.stall && !done) begin
                    if (sq_cnt <= 3'd1) begin
                        state_nxt  = BRS_RUN;
                        sq_cnt_nxt = '0;
                    end else begin
                        sq_cnt_nxt = sq_cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_nxt  = BRS_RUN;
                sq_cnt_nxt = '0;
            end
        endcase
    end

    // FSM outputs: only RUN (or the op that triggered the squash) resolves
    always_comb begin
        ctl     = bus.mem_valid && (is_br || is_unc) && ((state == BRS_RUN) || done);
        resolve = ctl && !bus.stall;
    end

    always_comb begin
        take       = ctl && (is_br ? |(bus.mem_nzp & bus.cc_nzp) : 1'b1);
        br_wrong   = (take != bus.mem_pred_taken) || (take && bus.mem_pred_taken && tgt_miss);
        unc_wrong  = !bus.mem_pred_taken || tgt_miss;
        wrong      = ctl && (is_br ? br_wrong : unc_wrong);
        mispredict = wrong && !done;
    end

    // done masks repeat redirects while the same op sits stalled in MEM
    always_ff @(posedge clk) begin
        if (rst)
            done <= 1'b0;
        else if (!bus.stall)
            done <= 1'b0;
        else if (ctl)
            done <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_take_q      <= 1'b0;
            wb_pred_q      <= 1'b0;
            wb_predictor_q <= 1'b0;
            resolved_pc_q  <= '0;
            btb_wtarget_q  <= '0;
            ubh_q          <= 1'b0;
            btb_we_q       <= 1'b0;
        end else begin
            ubh_q    <= resolve && is_br;
            btb_we_q <= resolve && take && tgt_miss;
            if (resolve) begin
                wb_take_q      <= take;
                wb_pred_q      <= bus.mem_pred_taken;
                wb_predictor_q <= bus.mem_predictor;
                resolved_pc_q  <= bus.mem_pc;
                btb_wtarget_q  <= bus.mem_actual_target;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve && wrong),
        .count (mispred_cnt)
    );

    assign bus.take_jump             = take;
    assign bus.bad_uncond_jump       = ctl && is_unc && unc_wrong;
    assign bus.mispredict            = mispredict;
    assign bus.redirect_pc           = take ? bus.mem_actual_target : bus.mem_pc + 16'd2;
    assign bus.wb_take_jump          = wb_take_q;
    assign bus.wb_predict_taken      = wb_pred_q;
    assign bus.wb_predictor          = wb_predictor_q;
    assign bus.resolved_pc           = resolved_pc_q;
    assign bus.update_branch_history = ubh_q;
    assign bus.btb_we                = btb_we_q;
    assign bus.btb_wtarget           = btb_wtarget_q;
    assign bus.branch_count          = branch_cnt;
    assign bus.mispredict_count      = mispred_cnt;

endmodule
